uart_transmitter: RTL and testbench

UART transmit half paired with the existing receiver. It shares the same sys_clk and the same bclkx8 oversampling strobe. It serialises bytes written into a single-entry transmit holding register (THR) through a transmit shift register (TSR) onto tx_out. The frame is 1 start bit, DATA_BITS data bits sent LSB first, and STOP_BITS stop bits. Each bit lasts 8 bclkx8 ticks, so the receiver's 4-tick mid-start and 8-tick data sampling land bit-centred.

---
 rtl/uart_transmitter.sv | 202 ++++++++++++++++++++
 tb/tb_uart_transmitter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmitter: single-entry THR feeding a TSR, 8 bclkx8 ticks per bit.
// Optional parity bit: define UART_TX_PARITY_EN (adds parameter PARITY_ODD).
module uart_transmitter #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 8
`ifdef UART_TX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       bclkx8,
  input  logic       tx_wr,
  input  logic [7:0] tx_din,
  output logic       thr_empty,
  output logic       tx_ovr,
  output logic       tx_status,
  output logic       tx_out
);

  // Upper tx_din bits are dropped at THR write so TSR and parity only ever see frame bits.
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [3:0] BIT_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] thr_q, thr_d;
  logic [7:0] tsr_q, tsr_d;
  logic       thr_empty_q, thr_empty_d;
  logic       tx_ovr_q, tx_ovr_d;
  logic       tx_out_q, tx_out_d;
  logic       bclk_old_q;
  logic       tick;
  logic       load;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  assign tick      = bclkx8 & ~bclk_old_q;
  assign thr_empty = thr_empty_q;
  assign tx_ovr    = tx_ovr_q;
  assign tx_out    = tx_out_q;
  assign tx_status = (state_q != S_IDLE);

  // Next-state: write handshake every cycle, FSM/counters/line only on tick cycles.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    thr_d       = thr_q;
    tsr_d       = tsr_q;
    thr_empty_d = thr_empty_q;
    tx_ovr_d    = 1'b0;
    tx_out_d    = tx_out_q;
    load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_out_d = 1'b1;
        if (tick && !thr_empty_q) begin
          load = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tx_out_d   = tsr_q[0];
            tsr_d      = {1'b0, tsr_q[7:1]};
            bit_cnt_d  = 3'd0;
            tick_cnt_d = 4'd0;
            state_d    = S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = 4'd0;
            if (bit_cnt_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx_out_d = parity_q;
              state_d  = S_PARITY;
`else
              tx_out_d = 1'b1;
              state_d  = S_STOP;
`endif
            end else begin
              tx_out_d  = tsr_q[0];
              tsr_d     = {1'b0, tsr_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tx_out_d   = 1'b1;
            tick_cnt_d = 4'd0;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == STOP_LAST) begin
            tick_cnt_d = 4'd0;
            if (!thr_empty_q) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        tx_out_d = 1'b1;
      end
    endcase

    // Writes and loads are exclusive: a write needs THR empty, a load needs it full.
    if (tx_wr) begin
      if (thr_empty_q) begin
        thr_d       = tx_din & DATA_MASK;
        thr_empty_d = 1'b0;
      end else begin
        tx_ovr_d = 1'b1;
      end
    end

    if (load) begin
      tsr_d       = thr_q;
      thr_empty_d = 1'b1;
      tx_out_d    = 1'b0;
      tick_cnt_d  = 4'd0;
      state_d     = S_START;
`ifdef UART_TX_PARITY_EN
      parity_d    = (^thr_q) ^ PARITY_ODD;
`endif
    end
  end

  // State register; bclk_old resets high so a high strobe at release is not a tick.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      thr_q       <= 8'd0;
      tsr_q       <= 8'd0;
      thr_empty_q <= 1'b1;
      tx_ovr_q    <= 1'b0;
      tx_out_q    <= 1'b1;
      bclk_old_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      thr_q       <= thr_d;
      tsr_q       <= tsr_d;
      thr_empty_q <= thr_empty_d;
      tx_ovr_q    <= tx_ovr_d;
      tx_out_q    <= tx_out_d;
      bclk_old_q  <= bclkx8;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench for uart_transmitter (default 8N1 build).
module tb_uart_transmitter;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       bclkx8  = 1'b0;
  logic       tx_wr   = 1'b0;
  logic [7:0] tx_din  = 8'd0;
  logic       thr_empty;
  logic       tx_ovr;
  logic       tx_status;
  logic       tx_out;

  uart_transmitter dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .bclkx8   (bclkx8),
    .tx_wr    (tx_wr),
    .tx_din   (tx_din),
    .thr_empty(thr_empty),
    .tx_ovr   (tx_ovr),
    .tx_status(tx_status),
    .tx_out   (tx_out)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb_q[$];
  int         frame_start_q[$];
  int         frames_rx  = 0;
  int         tick_total = 0;
  bit         bclk_run   = 1'b0;
  int         bclk_cnt   = 0;
  logic       mon_tick   = 1'b0;
  logic       mon_old    = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bclkx8 strobe: 2 cycles high, 2 low -> one tick every 4 sys_clk cycles.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (bclk_run) begin
        bclk_cnt++;
        bclkx8 = bclk_cnt[1];
      end
    end
  end

  always @(posedge sys_clk) begin
    mon_tick = bclkx8 & ~mon_old;
    mon_old  = bclkx8;
  end

  // Monitor: reconstruct frames from per-tick line samples, compare with scoreboard.
  logic       in_frame = 1'b0;
  logic       frame_ok = 1'b0;
  logic [9:0] bits     = 10'd0;
  int         pos      = 0;
  int         start_tick = 0;
  logic [7:0] exp_b;

  always @(negedge sys_clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (mon_tick) begin
      tick_total++;
      if (!in_frame && tx_out === 1'b0) begin
        in_frame   = 1'b1;
        pos        = 0;
        frame_ok   = 1'b1;
        start_tick = tick_total;
      end
      if (in_frame) begin
        if (pos % 8 == 0) bits[pos/8] = tx_out;
        else if (tx_out !== bits[pos/8]) frame_ok = 1'b0;
        if (tx_status !== 1'b1) frame_ok = 1'b0;
        pos++;
        if (pos == 80) begin
          in_frame = 1'b0;
          frames_rx++;
          frame_start_q.push_back(start_tick);
          chk("frame_shape", {29'd0, frame_ok, bits[0], bits[9]}, 32'd5);
          if (sb_q.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
          end else begin
            exp_b = sb_q.pop_front();
            chk("rx_byte", {24'd0, bits[8:1]}, {24'd0, exp_b});
          end
        end
      end
    end
  end

  task automatic write_byte(input logic [7:0] d);
    tx_din = d;
    tx_wr  = 1'b1;
    @(negedge sys_clk);
    tx_wr  = 1'b0;
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 200 && tx_status !== 1'b1; i++) @(negedge sys_clk);
    chk(name, {31'd0, tx_status}, 32'd1);
  endtask

  task automatic wait_frames(input string name, input int n);
    for (int i = 0; i < 2000 && frames_rx < n; i++) @(negedge sys_clk);
    chk(name, (frames_rx >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  int base;
  int s1, s2;

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_tx_out", {31'd0, tx_out}, 32'd1);
    chk("rst_thr_empty", {31'd0, thr_empty}, 32'd1);
    chk("rst_tx_ovr", {31'd0, tx_ovr}, 32'd0);
    chk("rst_tx_status", {31'd0, tx_status}, 32'd0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // 1: single byte 0x55
    sb_q.push_back(8'h55);
    write_byte(8'h55);
    chk("t1_thr_full", {31'd0, thr_empty}, 32'd0);
    chk("t1_no_ovr", {31'd0, tx_ovr}, 32'd0);
    bclk_run = 1'b1;
    wait_start("t1_start");
    chk("t1_thr_empty_at_start", {31'd0, thr_empty}, 32'd1);
    chk("t1_line_low_at_start", {31'd0, tx_out}, 32'd0);
    wait_frames("t1_frame", 1);
    repeat (12) @(negedge sys_clk);
    chk("t1_idle_after", {31'd0, tx_status}, 32'd0);
    chk("t1_line_high_after", {31'd0, tx_out}, 32'd1);

    // 2: back-to-back 0xA5 then 0x3C queued during the start bit
    base = frames_rx;
    sb_q.push_back(8'hA5);
    write_byte(8'hA5);
    wait_start("t2_start");
    repeat (6) @(negedge sys_clk);
    sb_q.push_back(8'h3C);
    write_byte(8'h3C);
    chk("t2_thr_full", {31'd0, thr_empty}, 32'd0);
    wait_frames("t2_frames", base + 2);
    if (frame_start_q.size() >= 2) begin
      s2 = frame_start_q[frame_start_q.size() - 1];
      s1 = frame_start_q[frame_start_q.size() - 2];
      chk("t2_gap_ticks", s2 - s1, 32'd80);
    end else begin
      chk("t2_gap_frames", frame_start_q.size(), 32'd2);
    end
    repeat (12) @(negedge sys_clk);

    // 3: overrun with bclkx8 stopped
    bclk_run = 1'b0;
    @(negedge sys_clk);
    bclkx8 = 1'b0;
    repeat (4) @(negedge sys_clk);
    base = frames_rx;
    sb_q.push_back(8'h11);
    tx_din = 8'h11;
    tx_wr  = 1'b1;
    @(negedge sys_clk);
    chk("t3_first_no_ovr", {31'd0, tx_ovr}, 32'd0);
    tx_din = 8'h22;
    @(negedge sys_clk);
    tx_wr = 1'b0;
    chk("t3_ovr_pulse", {31'd0, tx_ovr}, 32'd1);
    @(negedge sys_clk);
    chk("t3_ovr_one_cycle", {31'd0, tx_ovr}, 32'd0);
    chk("t3_still_idle", {31'd0, tx_status}, 32'd0);
    bclk_run = 1'b1;
    wait_frames("t3_frame", base + 1);
    repeat (400) @(negedge sys_clk);
    chk("t3_only_one_frame", frames_rx, base + 1);

    // 4: reset during data bit 3 of 0xF0 (frame discarded)
    write_byte(8'hF0);
    wait_start("t4_start");
    repeat (36 * 4) @(negedge sys_clk);
    chk("t4_mid_frame", {31'd0, tx_status}, 32'd1);
    base = frames_rx;
    rst_n = 1'b0;
    #1;
    chk("t4_async_line_high", {31'd0, tx_out}, 32'd1);
    chk("t4_async_status_low", {31'd0, tx_status}, 32'd0);
    chk("t4_thr_empty", {31'd0, thr_empty}, 32'd1);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (400) @(negedge sys_clk);
    chk("t4_no_frame_after", frames_rx, base);
    chk("t4_idle_after", {31'd0, tx_status}, 32'd0);

    // 5: reset release with bclkx8 held high
    bclk_run = 1'b0;
    @(negedge sys_clk);
    bclkx8 = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("t5_idle", {31'd0, tx_status}, 32'd0);
    chk("t5_line_high", {31'd0, tx_out}, 32'd1);
    base = frames_rx;
    sb_q.push_back(8'h5A);
    write_byte(8'h5A);
    repeat (20) @(negedge sys_clk);
    chk("t5_no_tick_while_high", {31'd0, tx_status}, 32'd0);
    bclkx8   = 1'b0;
    bclk_run = 1'b1;
    wait_frames("t5_frame", base + 1);

    repeat (20) @(negedge sys_clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
